// File: rtl/decoder_select_arbiter.sv
// Arbiter and grant timer in front of a 2-to-4 active-low decoder: picks one of four requesters,
// holds its enable window, then forces a blanking gap. Define ARB_FIXED_PRIO_EN for fixed priority.
module decoder_select_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       en_n,
  output logic       busy,
  output logic       done
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("decoder_select_arbiter: HOLD_CYCLES must be in 1..255");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("decoder_select_arbiter: GAP_CYCLES must be in 1..255");
  end
  if (CNT_W < 1 || CNT_W > 31 || (HOLD_CYCLES - 1) >= (1 << CNT_W) ||
      (GAP_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt
    $error("decoder_select_arbiter: CNT_W too narrow for HOLD_CYCLES/GAP_CYCLES");
  end

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic             en_n_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       pick_d;

`ifdef ARB_FIXED_PRIO_EN
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] res;
    res = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) res = 2'(k);
    end
    return res;
  endfunction

  always_comb begin
    pick_d = pick_fixed(req);
  end
`else
  logic [1:0] last_q;

  // Search order starts just after the last granted index and wraps back to it.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    pick_d = pick_rr(req, last_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      sel_q   <= 2'd0;
      en_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= 2'd3;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req != 4'b0000) begin
            state_q <= ST_GRANT;
            sel_q   <= pick_d;
            en_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= HOLD_LOAD;
          end
        end
        ST_GRANT: begin
          // sel is frozen for the whole window; req is deliberately ignored here.
          if (cnt_q == CNT_ZERO) begin
            state_q <= ST_GAP;
            en_n_q  <= 1'b1;
            done_q  <= 1'b1;
            cnt_q   <= GAP_LOAD;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= sel_q;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          en_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = sel_q;
  assign en_n = en_n_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Bench for decoder_select_arbiter: directed scenarios plus random requests, checked against a
// grant-timeline model (grant start edge, hold/gap lengths, pointer) rather than a state machine.
module tb_decoder_select_arbiter;
  localparam int H = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] sel;
  logic       en_n;
  logic       busy;
  logic       done;

  decoder_select_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .sel (sel),
    .en_n(en_n),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: edge counter, start edge of the most recent grant, earliest arbitration edge, pointer.
  int         e         = 0;
  int         gstart    = -1000;
  int         free_from = 0;
  int         ptr       = 3;
  logic [1:0] msel      = 2'd0;
  logic       prev_en_n = 1'b1;
  int         gq_idx[$];
  int         gq_edge[$];

  function automatic logic [1:0] ref_pick(input logic [3:0] r, input int p);
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) if (r[k]) return 2'(k);
    return 2'd0;
`else
    for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return 2'((p + k) % 4);
    return 2'(p);
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    int d;
    rst = r;
    req = q;
    @(posedge clk);
    e++;
    if (r) begin
      ptr = 3; msel = 2'd0; gstart = -1000; free_from = e + 1;
    end else if (e >= free_from && q != 4'b0000) begin
      msel = ref_pick(q, ptr); ptr = msel; gstart = e; free_from = e + H + G + 1;
    end
    d = e - gstart;
    #1;
    check("sel",  8'(sel),  8'(msel));
    check("en_n", 8'(en_n), 8'(!(d >= 0 && d < H)));
    check("busy", 8'(busy), 8'(d >= 0 && d < H + G));
    check("done", 8'(done), 8'(d == H));
    if (prev_en_n === 1'b1 && en_n === 1'b0) begin
      gq_idx.push_back(int'(sel));
      gq_edge.push_back(e);
    end
    prev_en_n = en_n;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;

    // Reset held two cycles with all requests up.
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    check("rst_sel", 8'(sel), 8'd0);
    check("rst_en_n", 8'(en_n), 8'd1);

    // Single one-cycle request for index 2.
    step(1'b0, 4'b0100);
    check("single_sel", 8'(sel), 8'd2);
    check("single_en_n", 8'(en_n), 8'd0);
    idle_steps(3);
    check("single_en_low_last", 8'(en_n), 8'd0);
    idle_steps(1);
    check("single_done", 8'(done), 8'd1);
    idle_steps(1);
    check("single_busy_drop", 8'(busy), 8'd0);
    idle_steps(3);

    // Continuous requests: rotation and spacing.
    step(1'b1, 4'b1111);
    gq_idx.delete();
    gq_edge.delete();
    for (int i = 0; i < 30; i++) step(1'b0, 4'b1111);
    check("rot_count_ge5", 8'(gq_idx.size() >= 5), 8'd1);
    if (gq_idx.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
`ifdef ARB_FIXED_PRIO_EN
        check("prio_all_zero", 8'(gq_idx[i]), 8'd0);
`else
        check("rot_order", 8'(gq_idx[i]), 8'(i % 4));
`endif
        if (i > 0) check("rot_spacing", 8'(gq_edge[i] - gq_edge[i-1]), 8'(H + G + 1));
      end
    end
    idle_steps(8);

    // Granted bit drops during the grant.
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    check("drop_en_n", 8'(en_n), 8'd0);
    idle_steps(8);

`ifdef ARB_FIXED_PRIO_EN
    gq_idx.delete();
    for (int i = 0; i < 20; i++) step(1'b0, 4'b1010);
    for (int i = 0; i < gq_idx.size(); i++) check("prio_1010", 8'(gq_idx[i]), 8'd1);
    idle_steps(8);
`endif

    // Reset in the second grant cycle restores the pointer.
    step(1'b1, 4'b1111);
    step(1'b0, 4'b1111);
    check("rmid_first_sel", 8'(sel), 8'd0);
    step(1'b0, 4'b1111);
    step(1'b1, 4'b1111);
    check("rmid_en_n", 8'(en_n), 8'd1);
    check("rmid_sel", 8'(sel), 8'd0);
    step(1'b0, 4'b1111);
    check("rmid_regrant_sel", 8'(sel), 8'd0);
    check("rmid_regrant_en_n", 8'(en_n), 8'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
